// File: rtl/apb_pkg.sv
// apb_pkg
//   Shared definitions for the APB4 memory completer: FSM state encoding,
//   default bus widths used by benches and integrators, and the pprot bit
//   that carries the privileged/unprivileged attribute.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  localparam int TB_DATA_WIDTH = 32;
  localparam int TB_ADDR_WIDTH = 12;

  // pprot[0] = 1 marks a privileged access
  localparam int PPROT_PRIV_BIT = 0;

endpackage

// File: rtl/apb_mem_bank.sv
// apb_mem_bank
//   DEPTH x DATA_WIDTH word store with per-byte write enables, asynchronous
//   clear of every word on reset and a registered read port.
// Ports:
//   pclk, presetn          clock, async active-low clear
//   wr_en, wr_idx          write strobe and word index
//   wr_data, wr_strb       write data and byte-lane enables
//   rd_en, rd_idx          read strobe and word index
//   rd_data                registered read data (updated when rd_en is high)
module apb_mem_bank #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int BYTES      = DATA_WIDTH / 8
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BYTES-1:0]      wr_strb,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        for (int b = 0; b < BYTES; b++) begin
          if (wr_strb[b]) begin
            mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
      if (rd_en) begin
        rd_data <= mem[rd_idx];
      end
    end
  end

endmodule

// File: rtl/apb4_mem_slave.sv
// apb4_mem_slave
//   APB4 completer in front of a byte-addressable word memory. Supports byte
//   write strobes, a fixed number of wait states, and error responses for
//   misaligned, out-of-range and (optionally) unprivileged accesses.
// Ports:
//   pclk, presetn                     clock, async active-low reset
//   pselx, penable, pwrite            APB control
//   paddr, pwdata, pstrb, pprot       APB request (byte address, data, lanes, protection)
//   prdata, pready, pslverr           APB response
//
// state      | meaning
// -----------+---------------------------------------------------------------
// APB_IDLE   | no transfer in flight; a setup phase (pselx & !penable) is
//            | captured on this cycle's edge
// APB_SETUP  | not held in normal operation: the setup phase is recognised
//            | combinationally and its edge loads APB_ACCESS directly, which
//            | is what lets a zero-wait transfer finish in two cycles
// APB_ACCESS | access phase; counter runs down, pready when it reaches 0
module apb4_mem_slave
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0,
  parameter bit PRIV_ONLY   = 1'b0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    pselx,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
  // one extra bit so DEPTH == 2**index_bits does not wrap to zero
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_STATES);

  apb_state_e state_q, state_d;

  logic [3:0]            cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BYTES-1:0]      strb_q;
  logic                  err_q;

  logic                  setup_seen;
  logic                  access_seen;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  err_d;
  logic                  capture;
  logic                  commit;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] bank_rdata;

  logic unused_prot;
  assign unused_prot = &{1'b0, pprot};

  assign setup_seen  = pselx & ~penable;
  assign access_seen = pselx & penable;
  assign word_idx    = paddr >> OFF_W;

  always_comb begin
    err_d = 1'b0;
    if ((paddr & ALIGN_MASK) != '0) err_d = 1'b1;
    if ({1'b0, word_idx} >= DEPTH_LIM) err_d = 1'b1;
    if (PRIV_ONLY && !pprot[PPROT_PRIV_BIT]) err_d = 1'b1;
  end

  // state register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= APB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      APB_IDLE: begin
        if (setup_seen) state_d = APB_ACCESS;
      end
      APB_SETUP: begin
        state_d = APB_ACCESS;
      end
      APB_ACCESS: begin
        if (!pselx) begin
          state_d = APB_IDLE;
        end else if (setup_seen) begin
          // access phase never arrived; treat this cycle as a fresh setup
          state_d = APB_ACCESS;
        end else if (access_seen && cnt_q == 4'd0) begin
          state_d = APB_IDLE;
        end
      end
      default: state_d = APB_IDLE;
    endcase
  end

  // outputs and datapath strobes, decoded from registered state only
  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    capture = 1'b0;
    commit  = 1'b0;
    rd_en   = 1'b0;
    if (state_q == APB_ACCESS) begin
      pready  = (cnt_q == 4'd0);
      pslverr = err_q;
      prdata  = err_q ? '0 : bank_rdata;
      // penable must be high as well: a recaptured setup with zero wait
      // states also shows pready, but must not write
      commit  = access_seen && (cnt_q == 4'd0) && write_q && !err_q;
    end
    if (state_q != APB_SETUP) begin
      capture = setup_seen;
    end
    rd_en = capture & ~err_d;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
    end else if (capture) begin
      cnt_q   <= WAIT_LOAD;
      idx_q   <= word_idx[IDX_W-1:0];
      write_q <= pwrite;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
      err_q   <= err_d;
    end else if (state_q == APB_ACCESS) begin
      if (!pselx) begin
        cnt_q <= '0;
      end else if (cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  apb_mem_bank #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W),
    .BYTES      (BYTES)
  ) u_bank (
    .pclk    (pclk),
    .presetn (presetn),
    .wr_en   (commit),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .wr_strb (strb_q),
    .rd_en   (rd_en),
    .rd_idx  (word_idx[IDX_W-1:0]),
    .rd_data (bank_rdata)
  );

endmodule

// File: doc/apb4_mem_slave.md
# apb4_mem_slave

Parametrised APB4 completer with byte-addressable word memory, programmable wait states, byte write strobes and error signalling. It is the next-generation slave behind the APB bus used by our environment: it adds `pstrb`, `pprot` checking and a configurable `pready` stretch to the plain APB slave. It is the DUT for the APB bench and a reusable peripheral model.

## Interface
- `DATA_WIDTH`, 32: `pwdata`/`prdata` width; must be 8, 16, 32 or 64.
- `ADDR_WIDTH`, 12: `paddr` width, byte address.
- `DEPTH`, 64: number of words; a power of 2, with `DEPTH*DATA_WIDTH/8 <= 2**ADDR_WIDTH`.
- `WAIT_STATES`, 0: access-phase cycles with `pready` low before completion; range 0..15.
- `PRIV_ONLY`, 0: when 1, accesses with `pprot[0]==0` (unprivileged) error.
- `pclk`, in, 1: clock, rising edge.
- `presetn`, in, 1: reset; one clock; reset is asynchronous and active-low.
- `pselx`, in, 1: select.
- `penable`, in, 1: access phase.
- `pwrite`, in, 1: 1 = write.
- `paddr`, in, `ADDR_WIDTH`: byte address.
- `pwdata`, in, `DATA_WIDTH`: write data.
- `pstrb`, in, `DATA_WIDTH/8`: write byte lanes.
- `pprot`, in, 3: protection; only bit 0 is used.
- `prdata`, out, `DATA_WIDTH`: read data, valid when `pready` is high on a read.
- `pready`, out, 1: transfer completes.
- `pslverr`, out, 1: error; meaningful only while `pready` is high.

## Operation
- **FSM states:** IDLE, SETUP, ACCESS.
  - IDLE→SETUP when `pselx & !penable`.
  - SETUP→ACCESS unconditionally. If `pselx` is low or `penable` stays low on the next cycle, the FSM returns to IDLE or SETUP accordingly and no side effect occurs.
  - ACCESS→IDLE on completion with `pselx` low next; ACCESS→SETUP if `pselx & !penable` next.
- **Setup capture:** on the SETUP-cycle edge, latch `paddr`, `pwrite`, `pwdata`, `pstrb`, compute the error flag, load the wait counter with `WAIT_STATES`, and register read data (0 if error).
- **Errors:**
  - misaligned address (`paddr[log2(DATA_WIDTH/8)-1:0] != 0`);
  - word index `>= DEPTH`;
  - `PRIV_ONLY && !pprot[0]`.
- **Writes:** commit only on the completing edge (`pready` high) and only if there is no error. Only lanes with `pstrb[i]` set update; `pstrb==0` completes with no change.
- **Errored transfers:** an errored write leaves memory untouched; an errored read returns `prdata` = 0.
- **Aborts:** `pselx` deasserted during ACCESS before `pready` returns the FSM to IDLE with no write and counter cleared.
- **Access-phase changes:** changes to `paddr`/`pwdata` during ACCESS are ignored; the latched values are used.
- **`penable` without setup:** `penable` high while in IDLE (no prior setup) is ignored; the FSM stays in IDLE and `pready` stays 0.

## Timing
- **Reset values:** `prdata`=0, `pready`=0, `pslverr`=0, FSM=IDLE, counter=0, all memory words = 0. Reset deassertion takes effect on the next `pclk` edge.
- **`pready`** = (state==ACCESS) && (counter==0), decoded from registers only; it is 0 in IDLE and SETUP.
- **Counter:** decrements by 1 each ACCESS cycle while nonzero.
- **Latency:** completion occurs in the access cycle numbered `WAIT_STATES+1`. Minimum transfer is 2 cycles; back-to-back transfers run 2+`WAIT_STATES` cycles each with no idle cycle.
- **Output validity:** `pslverr` and `prdata` are stable from the first ACCESS cycle through completion; both return to 0 the cycle after completion.
- **Read after write:** a read of the same address immediately after a write returns the new data (the write commits before the read's setup edge).
- **Reset mid-transfer:** all outputs drop immediately and the pending write is discarded.

## Structure
- **Package `apb_pkg`:** FSM state enum (`APB_IDLE`, `APB_SETUP`, `APB_ACCESS`), default width constants (`TB_DATA_WIDTH`, `TB_ADDR_WIDTH`), and the `pprot` bit-index constant.
- **Sub-module `apb_mem_bank`:** parametrised `DEPTH`×`DATA_WIDTH` array with per-byte write enable, asynchronous clear and registered read port.
- **Top level:** FSM, wait counter and error decode live in `apb4_mem_slave`.

## Test plan
- **Reset:** assert `presetn`=0 mid-write → outputs 0 immediately. After release, a read of address 0x00 returns 0x0000_0000 with `pslverr`=0.
- **Write/read, `WAIT_STATES`=0:** write 0xDEADBEEF to 0x10 with `pstrb`=0xF → `pready` high in the 2nd cycle. Reading 0x10 back returns 0xDEADBEEF.
- **Strobes:** write 0x11223344 to 0x10 with `pstrb`=0x5 → readback 0xDE22BE44.
- **Errors:**
  - Misaligned 0x12 → `pslverr`=1, `prdata`=0.
  - 0x100 with `DEPTH`=64 → `pslverr`=1 and no memory change.
  - With `PRIV_ONLY`=1 and `pprot`=0 → `pslverr`=1.
- **`WAIT_STATES`=3:** `pready` stays low for 3 access cycles and rises in the 4th. Back-to-back write then read complete in 5 cycles each.
- **Abort:** drop `pselx` in the 2nd access cycle with `WAIT_STATES`=3 → no write, FSM back to IDLE, the next transfer behaves normally.
